// File: rtl/mmu_axi_pkg.sv
// Shared types for the MMU AXI read arbiter: FSM states, AR field bundle, AXI encodings.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package mmu_axi_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR_D = 3'd1,
        AR_I = 3'd2,
        R_D  = 3'd3,
        R_I  = 3'd4
    } arb_state_t;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [7:0] AXI_LEN_CACHED  = 8'd15;
    localparam logic [2:0] AXI_SIZE_WORD   = 3'b010;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_req_t;

    // Cached reads are 16-beat word INCR bursts (one cache line); uncached
    // reads are single beats. Only the data side may pick a narrower size.
    function automatic ar_req_t build_ar(input logic [31:0] addr,
                                         input logic        uncached,
                                         input logic        is_data,
                                         input logic [2:0]  size);
        ar_req_t r;
        r.addr  = addr;
        r.len   = uncached ? 8'd0 : AXI_LEN_CACHED;
        r.burst = uncached ? AXI_BURST_FIXED : AXI_BURST_INCR;
        r.size  = (uncached && is_data) ? size : AXI_SIZE_WORD;
        return r;
    endfunction

endpackage

// File: rtl/mmu_axi_rd_arbiter.sv
// Arbitrates inst/data read requesters onto one AXI read channel, one burst in flight.
// Latency: arvalid one cycle after the request is sampled; next arvalid two cycles after rlast.
// Backpressure: arvalid held with stable fields until arready; rready high only in R states.
//
// Ports: clk/rst (async active-low); i_* inst requester; d_* data requester;
// ar*/r* AXI read address and read data handshake signals.
// Optional: define ARB_STARVE_GUARD_EN to let a waiting inst request win after
// STARVE_LIMIT consecutive data grants; otherwise data has strict priority.
module mmu_axi_rd_arbiter
    import mmu_axi_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    // inst requester
    input  logic        i_valid,
    input  logic [31:0] i_addr,
    input  logic        i_uncached,
    output logic        i_ok,
    output logic        i_rvalid,
    output logic        i_rlast,
    // data requester
    input  logic        d_valid,
    input  logic [31:0] d_addr,
    input  logic        d_uncached,
    input  logic [2:0]  d_size,
    output logic        d_ok,
    output logic        d_rvalid,
    output logic        d_rlast,
    // AXI read address channel
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    // AXI read data channel (payload is routed outside this block)
    input  logic        rvalid,
    input  logic        rlast,
    output logic        rready
);

    if (STARVE_LIMIT < 1) begin : g_limit_check
        $error("STARVE_LIMIT must be at least 1");
    end

    arb_state_t state_q, state_d;
    ar_req_t    ar_q;
    logic       grant_d, grant_i;
    logic       starve_hit;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_q;

    assign starve_hit = (starve_q >= CNT_W'(STARVE_LIMIT));

    // Counts data grants that overtook a waiting inst request; any inst grant
    // clears it. Increments stop once the limit is reached.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
        end else if (grant_i) begin
            starve_q <= '0;
        end else if (grant_d && i_valid && !starve_hit) begin
            starve_q <= starve_q + CNT_W'(1);
        end
    end
`else
    assign starve_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = 1'b0;
        grant_i  = 1'b0;
        arvalid  = 1'b0;
        rready   = 1'b0;
        i_ok     = 1'b0;
        d_ok     = 1'b0;
        i_rvalid = 1'b0;
        i_rlast  = 1'b0;
        d_rvalid = 1'b0;
        d_rlast  = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_valid && !(i_valid && starve_hit)) begin
                    grant_d = 1'b1;
                    state_d = AR_D;
                end else if (i_valid) begin
                    grant_i = 1'b1;
                    state_d = AR_I;
                end
            end
            // Requester valid is not looked at here: once issued, AR cannot be withdrawn.
            AR_D: begin
                arvalid = 1'b1;
                if (arready) begin
                    d_ok    = 1'b1;
                    state_d = R_D;
                end
            end
            AR_I: begin
                arvalid = 1'b1;
                if (arready) begin
                    i_ok    = 1'b1;
                    state_d = R_I;
                end
            end
            R_D: begin
                rready   = 1'b1;
                d_rvalid = rvalid;
                d_rlast  = rlast;
                if (rvalid && rlast) begin
                    state_d = IDLE;
                end
            end
            R_I: begin
                rready   = 1'b1;
                i_rvalid = rvalid;
                i_rlast  = rlast;
                if (rvalid && rlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // AR fields are captured only on the grant edge so they stay frozen for
    // the whole address phase regardless of what the requester does.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ar_q <= '0;
        end else if (grant_d) begin
            ar_q <= build_ar(d_addr, d_uncached, 1'b1, d_size);
        end else if (grant_i) begin
            ar_q <= build_ar(i_addr, i_uncached, 1'b0, 3'b000);
        end
    end

    assign araddr  = ar_q.addr;
    assign arlen   = ar_q.len;
    assign arsize  = ar_q.size;
    assign arburst = ar_q.burst;

endmodule

// File: tb/tb_mmu_axi_rd_arbiter.sv
// Testbench for mmu_axi_rd_arbiter: scenario tasks plus randomized traffic
// checked against a transaction-level arbitration model.
// Inputs driven 1 time unit after the rising edge; outputs sampled 2 units after.
module tb_mmu_axi_rd_arbiter;

    localparam int LIMIT = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        i_valid, i_uncached, i_ok, i_rvalid, i_rlast;
    logic [31:0] i_addr;
    logic        d_valid, d_uncached, d_ok, d_rvalid, d_rlast;
    logic [31:0] d_addr;
    logic [2:0]  d_size;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready, rvalid, rlast, rready;

    int tests  = 0;
    int failed = 0;

    // results of the most recent axi_serve call
    logic [31:0] c_addr;
    logic [7:0]  c_len;
    logic [2:0]  c_size;
    logic [1:0]  c_burst;
    int          c_wait, c_ib, c_db, c_il, c_dl, c_iok, c_dok;
    bit          c_err;

    mmu_axi_rd_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_addr(i_addr), .i_uncached(i_uncached),
        .i_ok(i_ok), .i_rvalid(i_rvalid), .i_rlast(i_rlast),
        .d_valid(d_valid), .d_addr(d_addr), .d_uncached(d_uncached), .d_size(d_size),
        .d_ok(d_ok), .d_rvalid(d_rvalid), .d_rlast(d_rlast),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rvalid(rvalid), .rlast(rlast), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b0;
        i_valid = 0; i_addr = '0; i_uncached = 0;
        d_valid = 0; d_addr = '0; d_uncached = 0; d_size = '0;
        arready = 0; rvalid = 0; rlast = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // AXI slave + requester behaviour for one burst. Entered and left at a
    // drive point (1 unit after an edge). Records what it observed.
    task automatic axi_serve(input int ar_delay, input int nbeats, input bit drop,
                             output logic [31:0] o_addr, output logic [7:0] o_len,
                             output logic [2:0] o_size, output logic [1:0] o_burst,
                             output int o_wait, output int o_ib, output int o_db,
                             output int o_il, output int o_dl,
                             output int o_iok, output int o_dok, output bit o_err);
        int gap;
        o_addr = '0; o_len = '0; o_size = '0; o_burst = '0;
        o_wait = 0; o_ib = 0; o_db = 0; o_il = 0; o_dl = 0; o_iok = 0; o_dok = 0; o_err = 0;
        #1;
        while (arvalid !== 1'b1 && o_wait < 100) begin
            o_iok += int'(i_ok); o_dok += int'(d_ok);
            @(posedge clk); #2;
            o_wait++;
        end
        if (arvalid !== 1'b1) begin
            o_err = 1'b1;
            @(posedge clk); #1;
            return;
        end
        o_addr = araddr; o_len = arlen; o_size = arsize; o_burst = arburst;
        for (int k = 0; k < ar_delay; k++) begin
            if (arvalid !== 1'b1 || araddr !== o_addr || arlen !== o_len ||
                arsize !== o_size || arburst !== o_burst || rready !== 1'b0)
                o_err = 1'b1;
            o_iok += int'(i_ok); o_dok += int'(d_ok);
            @(posedge clk); #2;
        end
        if (arvalid !== 1'b1 || araddr !== o_addr) o_err = 1'b1;
        arready = 1'b1;
        #1;
        o_iok += int'(i_ok); o_dok += int'(d_ok);
        if (drop) begin
            if (i_ok === 1'b1) i_valid = 1'b0;
            if (d_ok === 1'b1) d_valid = 1'b0;
        end
        @(posedge clk); #1;
        arready = 1'b0;
        #1;
        if (arvalid !== 1'b0 || rready !== 1'b1) o_err = 1'b1;
        o_iok += int'(i_ok); o_dok += int'(d_ok);
        for (int b = 0; b < nbeats; b++) begin
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
                rvalid = 1'b0; rlast = 1'b0;
                #1;
                if (rready !== 1'b1) o_err = 1'b1;
                o_ib += int'(i_rvalid); o_db += int'(d_rvalid);
                o_il += int'(i_rlast);  o_dl += int'(d_rlast);
                o_iok += int'(i_ok); o_dok += int'(d_ok);
            end
            @(posedge clk); #1;
            rvalid = 1'b1; rlast = (b == nbeats - 1);
            #1;
            if (rready !== 1'b1) o_err = 1'b1;
            o_ib += int'(i_rvalid); o_db += int'(d_rvalid);
            o_il += int'(i_rlast);  o_dl += int'(d_rlast);
            o_iok += int'(i_ok); o_dok += int'(d_ok);
        end
        @(posedge clk); #1;
        rvalid = 1'b0; rlast = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests++;
        if ({arvalid, rready, i_ok, d_ok, i_rvalid, i_rlast, d_rvalid, d_rlast} !== 8'h00) begin
            $display("FAIL reset_ctrl: got %b, expected 00000000",
                     {arvalid, rready, i_ok, d_ok, i_rvalid, i_rlast, d_rvalid, d_rlast});
            failed++;
        end
        tests++;
        if ({araddr, arlen, arsize, arburst} !== 45'd0) begin
            $display("FAIL reset_ar: got addr=%h len=%0d size=%b burst=%b, expected all 0",
                     araddr, arlen, arsize, arburst);
            failed++;
        end
        // stray read data while idle must not reach either requester
        rvalid = 1'b1; rlast = 1'b1;
        #1;
        tests++;
        if ({rready, i_rvalid, i_rlast, d_rvalid, d_rlast} !== 5'b0) begin
            $display("FAIL idle_rvalid_ignored: got %b, expected 00000",
                     {rready, i_rvalid, i_rlast, d_rvalid, d_rlast});
            failed++;
        end
        @(posedge clk); #1;
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        tests++;
        if (arvalid !== 1'b0) begin
            $display("FAIL idle_stays_idle: arvalid got %b, expected 0", arvalid);
            failed++;
        end
    endtask

    task automatic test_inst_cached();
        do_reset();
        i_valid = 1'b1; i_addr = 32'h1fc0_0000; i_uncached = 1'b0;
        #1;
        tests++;
        if (arvalid !== 1'b0) begin
            $display("FAIL inst_arvalid_early: got %b, expected 0", arvalid);
            failed++;
        end
        @(posedge clk); #1;
        axi_serve(int'($urandom_range(1, 4)), 16, 1'b1, c_addr, c_len, c_size, c_burst,
                  c_wait, c_ib, c_db, c_il, c_dl, c_iok, c_dok, c_err);
        tests++;
        if (c_wait != 0) begin
            $display("FAIL inst_arvalid_rise: waited %0d cycles, expected 0", c_wait);
            failed++;
        end
        tests++;
        if (c_addr !== 32'h1fc0_0000 || c_len !== 8'd15 || c_burst !== 2'b01 || c_size !== 3'b010) begin
            $display("FAIL inst_ar_fields: got addr=%h len=%0d burst=%b size=%b, expected 1fc00000 15 01 010",
                     c_addr, c_len, c_burst, c_size);
            failed++;
        end
        tests++;
        if (c_ib != 16 || c_il != 1 || c_db != 0 || c_dl != 0) begin
            $display("FAIL inst_beats: got i_beats=%0d i_last=%0d d_beats=%0d d_last=%0d, expected 16 1 0 0",
                     c_ib, c_il, c_db, c_dl);
            failed++;
        end
        tests++;
        if (c_iok != 1 || c_dok != 0 || c_err) begin
            $display("FAIL inst_ok: got i_ok=%0d d_ok=%0d err=%0d, expected 1 0 0", c_iok, c_dok, c_err);
            failed++;
        end
        #1;
        tests++;
        if (rready !== 1'b0 || arvalid !== 1'b0) begin
            $display("FAIL inst_back_idle: got rready=%b arvalid=%b, expected 0 0", rready, arvalid);
            failed++;
        end
    endtask

    task automatic test_both_same_cycle();
        logic [31:0] da, ia;
        do_reset();
        da = $urandom & 32'hffff_fffc;
        ia = $urandom & 32'hffff_fffc;
        d_valid = 1'b1; d_addr = da; d_uncached = 1'b1; d_size = 3'b001;
        i_valid = 1'b1; i_addr = ia; i_uncached = 1'b0;
        axi_serve(int'($urandom_range(0, 3)), 1, 1'b1, c_addr, c_len, c_size, c_burst,
                  c_wait, c_ib, c_db, c_il, c_dl, c_iok, c_dok, c_err);
        tests++;
        if (c_addr !== da || c_len !== 8'd0 || c_size !== 3'b001 || c_burst !== 2'b00 ||
            c_dok != 1 || c_iok != 0) begin
            $display("FAIL both_data_first: got addr=%h len=%0d size=%b burst=%b d_ok=%0d i_ok=%0d, expected %h 0 001 00 1 0",
                     c_addr, c_len, c_size, c_burst, c_dok, c_iok, da);
            failed++;
        end
        tests++;
        if (c_db != 1 || c_dl != 1 || c_ib != 0 || c_il != 0 || c_err) begin
            $display("FAIL both_data_beat: got d=%0d/%0d i=%0d/%0d err=%0d, expected 1/1 0/0 0",
                     c_db, c_dl, c_ib, c_il, c_err);
            failed++;
        end
        #1;
        tests++;
        if (arvalid !== 1'b0) begin
            $display("FAIL both_gap_after_last: arvalid got %b, expected 0", arvalid);
            failed++;
        end
        @(posedge clk); #1;
        axi_serve(int'($urandom_range(0, 3)), 16, 1'b1, c_addr, c_len, c_size, c_burst,
                  c_wait, c_ib, c_db, c_il, c_dl, c_iok, c_dok, c_err);
        tests++;
        if (c_wait != 0 || c_addr !== ia || c_len !== 8'd15 || c_size !== 3'b010 || c_burst !== 2'b01) begin
            $display("FAIL both_inst_second: got wait=%0d addr=%h len=%0d size=%b burst=%b, expected 0 %h 15 010 01",
                     c_wait, c_addr, c_len, c_size, c_burst, ia);
            failed++;
        end
        tests++;
        if (c_ib != 16 || c_il != 1 || c_db != 0 || c_iok != 1 || c_dok != 0 || c_err) begin
            $display("FAIL both_inst_beats: got i=%0d/%0d d=%0d ok=%0d/%0d err=%0d, expected 16/1 0 1/0 0",
                     c_ib, c_il, c_db, c_iok, c_dok, c_err);
            failed++;
        end
    endtask

    task automatic test_ar_hold();
        logic [31:0] da, cap_addr;
        logic [7:0]  cap_len;
        logic [2:0]  cap_size;
        int          bad;
        do_reset();
        da = $urandom & 32'hffff_fffc;
        d_valid = 1'b1; d_addr = da; d_uncached = 1'b1; d_size = 3'b000;
        @(posedge clk); #1;
        d_valid = 1'b0;
        d_addr = ~da;
        #1;
        cap_addr = araddr; cap_len = arlen; cap_size = arsize;
        tests++;
        if (arvalid !== 1'b1 || cap_addr !== da || cap_len !== 8'd0 || cap_size !== 3'b000) begin
            $display("FAIL hold_fields: got arvalid=%b addr=%h len=%0d size=%b, expected 1 %h 0 000",
                     arvalid, cap_addr, cap_len, cap_size, da);
            failed++;
        end
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #2;
            if (arvalid !== 1'b1 || araddr !== cap_addr || arlen !== cap_len ||
                arsize !== cap_size || d_ok !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            $display("FAIL hold_stable: got %0d unstable cycles, expected 0", bad);
            failed++;
        end
        arready = 1'b1;
        #1;
        tests++;
        if (d_ok !== 1'b1 || i_ok !== 1'b0) begin
            $display("FAIL hold_ok: got d_ok=%b i_ok=%b, expected 1 0", d_ok, i_ok);
            failed++;
        end
        @(posedge clk); #1;
        arready = 1'b0; rvalid = 1'b1; rlast = 1'b1;
        #1;
        tests++;
        if ({rready, d_rvalid, d_rlast, i_rvalid, i_rlast, arvalid} !== 6'b111000) begin
            $display("FAIL hold_beat: got %b, expected 111000",
                     {rready, d_rvalid, d_rlast, i_rvalid, i_rlast, arvalid});
            failed++;
        end
        @(posedge clk); #1;
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        tests++;
        if (rready !== 1'b0 || arvalid !== 1'b0) begin
            $display("FAIL hold_idle: got rready=%b arvalid=%b, expected 0 0", rready, arvalid);
            failed++;
        end
    endtask

    task automatic test_starvation();
        bit exp_inst, got_inst;
        do_reset();
        d_valid = 1'b1; d_addr = 32'h0000_1000; d_uncached = 1'b1; d_size = 3'b010;
        i_valid = 1'b1; i_addr = 32'h0000_2000; i_uncached = 1'b1;
        for (int k = 0; k < 11; k++) begin
            axi_serve(int'($urandom_range(0, 2)), 1, 1'b0, c_addr, c_len, c_size, c_burst,
                      c_wait, c_ib, c_db, c_il, c_dl, c_iok, c_dok, c_err);
            exp_inst = GUARD && ((k % (LIMIT + 1)) == LIMIT);
            got_inst = (c_iok == 1);
            tests++;
            if (got_inst !== exp_inst || (c_iok + c_dok) != 1 || c_err ||
                c_addr !== (exp_inst ? 32'h0000_2000 : 32'h0000_1000)) begin
                $display("FAIL starve_grant_%0d: got inst=%b ok=%0d/%0d addr=%h err=%0d, expected inst=%b",
                         k, got_inst, c_iok, c_dok, c_addr, c_err, exp_inst);
                failed++;
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int n, beats;
        do_reset();
        i_valid = 1'b1; i_addr = 32'h1fc0_0040; i_uncached = 1'b0;
        n = 0;
        #1;
        while (arvalid !== 1'b1 && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        arready = 1'b1;
        #1;
        tests++;
        if (i_ok !== 1'b1) begin
            $display("FAIL rstmid_ar_ok: got i_ok=%b, expected 1", i_ok);
            failed++;
        end
        i_valid = 1'b0;
        @(posedge clk); #1;
        arready = 1'b0;
        beats = 0;
        for (int b = 0; b < 6; b++) begin
            @(posedge clk); #1;
            rvalid = 1'b1; rlast = 1'b0;
            #1;
            beats += int'(i_rvalid);
        end
        @(posedge clk); #1;
        rvalid = 1'b1; rlast = 1'b0;
        rst = 1'b0;
        #1;
        tests++;
        if (beats != 6) begin
            $display("FAIL rstmid_beats_before: got %0d, expected 6", beats);
            failed++;
        end
        tests++;
        if ({arvalid, rready, i_ok, d_ok, i_rvalid, i_rlast, d_rvalid, d_rlast} !== 8'h00 ||
            {araddr, arlen, arsize, arburst} !== 45'd0) begin
            $display("FAIL rstmid_outputs: got ctrl=%b addr=%h len=%0d size=%b burst=%b, expected all 0",
                     {arvalid, rready, i_ok, d_ok, i_rvalid, i_rlast, d_rvalid, d_rlast},
                     araddr, arlen, arsize, arburst);
            failed++;
        end
        rvalid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        d_valid = 1'b1; d_addr = 32'h0000_0ff0; d_uncached = 1'b1; d_size = 3'b001;
        axi_serve(2, 1, 1'b1, c_addr, c_len, c_size, c_burst,
                  c_wait, c_ib, c_db, c_il, c_dl, c_iok, c_dok, c_err);
        tests++;
        if (c_addr !== 32'h0000_0ff0 || c_size !== 3'b001 || c_db != 1 || c_dl != 1 ||
            c_dok != 1 || c_iok != 0 || c_ib != 0 || c_il != 0 || c_err) begin
            $display("FAIL rstmid_after: got addr=%h size=%b d=%0d/%0d ok=%0d/%0d i=%0d/%0d err=%0d, expected 00000ff0 001 1/1 1/0 0/0 0",
                     c_addr, c_size, c_db, c_dl, c_dok, c_iok, c_ib, c_il, c_err);
            failed++;
        end
    endtask

    // Randomized traffic against a transaction model: each requester holds its
    // request until granted; data wins unless the inst request has been
    // overtaken LIMIT times (guard builds only).
    task automatic test_random();
        bit          dp, ip, du, iu, win_d, e_unc;
        logic [31:0] da, ia, e_addr;
        logic [2:0]  ds, e_size;
        int          starve, nb;
        do_reset();
        dp = 0; ip = 0; starve = 0;
        da = '0; ia = '0; du = 0; iu = 0; ds = '0;
        for (int r = 0; r < 30; r++) begin
            if (!dp && $urandom_range(0, 2) != 0) begin
                dp = 1; da = $urandom & 32'hffff_fffc; du = 1'($urandom_range(0, 1));
                ds = 3'($urandom_range(0, 2));
                d_valid = 1'b1; d_addr = da; d_uncached = du; d_size = ds;
            end
            if (!ip && ($urandom_range(0, 2) != 0 || !dp)) begin
                ip = 1; ia = $urandom & 32'hffff_fffc; iu = 1'($urandom_range(0, 1));
                i_valid = 1'b1; i_addr = ia; i_uncached = iu;
            end
            win_d = dp && !(GUARD && ip && starve >= LIMIT);
            if (win_d) begin
                if (ip && starve < LIMIT) starve++;
            end else begin
                starve = 0;
            end
            e_unc  = win_d ? du : iu;
            e_addr = win_d ? da : ia;
            e_size = (win_d && du) ? ds : 3'b010;
            nb     = e_unc ? 1 : 16;
            axi_serve(int'($urandom_range(0, 3)), nb, 1'b1, c_addr, c_len, c_size, c_burst,
                      c_wait, c_ib, c_db, c_il, c_dl, c_iok, c_dok, c_err);
            tests++;
            if (c_addr !== e_addr || c_len !== (e_unc ? 8'd0 : 8'd15) ||
                c_burst !== (e_unc ? 2'b00 : 2'b01) || c_size !== e_size) begin
                $display("FAIL rand_ar_%0d: got addr=%h len=%0d burst=%b size=%b, expected addr=%h unc=%b size=%b",
                         r, c_addr, c_len, c_burst, c_size, e_addr, e_unc, e_size);
                failed++;
            end
            tests++;
            if (c_err || c_dok != int'(win_d) || c_iok != int'(!win_d) ||
                c_db != (win_d ? nb : 0) || c_ib != (win_d ? 0 : nb) ||
                c_dl != int'(win_d) || c_il != int'(!win_d)) begin
                $display("FAIL rand_xfer_%0d: got ok=%0d/%0d beats=%0d/%0d last=%0d/%0d err=%0d, expected win_d=%b beats=%0d",
                         r, c_dok, c_iok, c_db, c_ib, c_dl, c_il, c_err, win_d, nb);
                failed++;
            end
            if (win_d) dp = 0; else ip = 0;
        end
    endtask

    initial begin
        test_reset();
        test_inst_cached();
        test_both_same_cycle();
        test_ar_hold();
        test_starvation();
        test_reset_mid_burst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
